mc_ctrl_fsm: RTL
================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
//  Sits directly upstream of the ALU decoder and drives its 2-bit aluop; also drives all datapath enables/muxes.
//  Supports lw, sw, R-type, beq, addi, j; memory accesses stall on a ready handshake.
// PARAMETERS
//  HALT_ON_ILLEGAL  1  1: unknown opcode -> sticky HALT; 0: unknown opcode -> back to FETCH
// PORTS
//  clk        in   1  single clock, rising edge
//  reset      in   1  synchronous, active-high
//  op         in   6  instr[31:26] from instruction register
//  zero       in   1  ALU zero flag
//  memready   in   1  memory completes current access this cycle
//  memreq     out  1  memory access requested (FETCH, MEMRD, MEMWR)
//  memwrite   out  1  store strobe (MEMWR only)
//  irwrite    out  1  load IR (FETCH & memready)
//  pcen       out  1  (pcwrite & (FETCH ? memready : 1)) | (branch & zero)
//  regwrite   out  1  register file write
//  iord, alusrca, regdst, memtoreg  out 1 each  datapath mux selects
//  alusrcb    out  2  00 rd2, 01 const 4, 10 signimm, 11 signimm<<2
//  pcsrc      out  2  00 aluresult, 01 aluout, 10 jump target
//  aluop      out  2  00 add, 01 sub, 10 use funct (to ALU decoder)
//  illegal    out  1  high while in HALT
// BEHAVIOUR
//  - Reset: state <= FETCH; no other state. All outputs are decoded from state (+memready/zero as noted);
//    in reset-exit FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, memreq=1, others 0.
//  - reset wins over all transitions, including mid-access stalls and HALT; outstanding access is abandoned.
//  - States/transitions:
//    FETCH  -> DECODE when memready, else stay (irwrite, pcen held low until memready)
//    DECODE (alusrcb=11, aluop=00): lw/sw->MEMADR, R(000000)->RTYPEEX, beq(000100)->BEQEX,
//           addi(001000)->ADDIEX, j(000010)->JEX, other->HALT or FETCH per HALT_ON_ILLEGAL
//    MEMADR (alusrca=1, alusrcb=10): lw(100011)->MEMRD, sw(101011)->MEMWR
//    MEMRD  (iord=1, memreq) -> MEMWB when memready, else stay
//    MEMWB  (regdst=0, memtoreg=1, regwrite) -> FETCH
//    MEMWR  (iord=1, memreq, memwrite) -> FETCH when memready, else stay (memwrite held)
//    RTYPEEX(alusrca=1, alusrcb=00, aluop=10) -> RTYPEWB(regdst=1, regwrite) -> FETCH
//    BEQEX  (alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch) -> FETCH
//    ADDIEX (alusrca=1, alusrcb=10, aluop=00) -> ADDIWB(regdst=0, regwrite) -> FETCH
//    JEX    (pcsrc=10, pcwrite) -> FETCH
//    HALT   (illegal=1, all enables 0) -> HALT until reset
//  - Latency (memready tied 1): lw 5, sw 4, R/addi 4, beq/j 3 cycles.
//  - op sampled combinationally in DECODE and MEMADR only; IR is stable then (irwrite low).
//  - Unreached outputs are 0, never x; default case of state decode -> FETCH.
// CONFIGURATION
//  MC_CTRL_BNE_EN defined: opcode 000101 in DECODE -> BNEEX (as BEQEX but pcen = ~zero), -> FETCH.
//  Undefined: 000101 treated as illegal; BNEEX absent from the enum.
// STRUCTURE
//  mc_ctrl_pkg: state_t enum, opcode localparams (OP_RTYPE/LW/SW/BEQ/BNE/ADDI/J), aluop and
//    alusrcb/pcsrc encodings; shared with ALU decoder and datapath.
//  Sub-module mc_ctrl_outdec: combinational state -> control word; top holds state reg,
//    next-state logic, memready/zero gating of pcen/irwrite.
// TESTING
//  lw op=100011, memready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 & memtoreg=1 only in cycle 5.
//  R-type op=000000 -> aluop=10 in RTYPEEX, regdst=1 regwrite=1 next cycle, back to FETCH.
//  beq zero=1 -> pcen=1 in BEQEX; zero=0 -> pcen=0; both return to FETCH after 3 cycles.
//  FETCH with memready=0 for 3 cycles -> state held, irwrite=pcen=0; memready=1 -> irwrite=pcen=1 once.
//  op=111111, HALT_ON_ILLEGAL=1 -> illegal=1 sticky, no enables; reset=1 -> FETCH next edge.
//  reset asserted in MEMWR stall -> FETCH next cycle, memwrite=0; with MC_CTRL_BNE_EN, op=000101 zero=0 -> pcen=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller, ALU decoder and datapath.
// MC_CTRL_BNE_EN adds the BNEEX state and bne support.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RD2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX,
`ifdef MC_CTRL_BNE_EN
    S_BNEEX,
`endif
    S_HALT
  } state_t;

  // Raw per-state control word; memready/zero gating is applied by the top.
  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: current state -> raw control word.
// MC_CTRL_BNE_EN adds the BNEEX decode.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.memreq  = 1'b1;
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
        cw.alusrcb = SRCB_FOUR;
        cw.aluop   = ALUOP_ADD;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMM_SH2;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        cw.iord   = 1'b1;
        cw.memreq = 1'b1;
      end
      S_MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_MEMWR: begin
        cw.iord     = 1'b1;
        cw.memreq   = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RD2;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_BEQEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RD2;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEEX: begin
        cw.alusrca   = 1'b1;
        cw.alusrcb   = SRCB_RD2;
        cw.aluop     = ALUOP_SUB;
        cw.pcsrc     = PCSRC_ALUOUT;
        cw.branch_ne = 1'b1;
      end
`endif
      S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        cw.regwrite = 1'b1;
      end
      S_JEX: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      S_HALT: begin
        cw.illegal = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic, memready/zero gating.
// MC_CTRL_BNE_EN enables bne (opcode 000101) via the BNEEX state.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output state_t     state_dbg
);

  // Memory handshake: memreq stays high in FETCH/MEMRD/MEMWR until a cycle with
  // memready=1; that cycle completes the access and the FSM moves on at the next edge.
  state_t state, state_next;
  ctrl_t  cw;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (memready) state_next = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(op))       state_next = S_MEMADR;
        else if (op == OP_RTYPE) state_next = S_RTYPEEX;
        else if (op == OP_BEQ)   state_next = S_BEQEX;
        else if (op == OP_ADDI)  state_next = S_ADDIEX;
        else if (op == OP_J)     state_next = S_JEX;
`ifdef MC_CTRL_BNE_EN
        else if (op == OP_BNE)   state_next = S_BNEEX;
`endif
        else                     state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   if (memready) state_next = S_MEMWB;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   if (memready) state_next = S_FETCH;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_RTYPEWB: state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
`ifdef MC_CTRL_BNE_EN
      S_BNEEX:   state_next = S_FETCH;
`endif
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JEX:     state_next = S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (state),
    .cw    (cw)
  );

  // PC/IR updates in FETCH must wait for the instruction word to arrive.
  assign pcen      = (cw.pcwrite & ((state == S_FETCH) ? memready : 1'b1))
                   | (cw.branch & zero) | (cw.branch_ne & ~zero);
  assign irwrite   = cw.irwrite & memready;
  assign memreq    = cw.memreq;
  assign memwrite  = cw.memwrite;
  assign regwrite  = cw.regwrite;
  assign iord      = cw.iord;
  assign alusrca   = cw.alusrca;
  assign regdst    = cw.regdst;
  assign memtoreg  = cw.memtoreg;
  assign alusrcb   = cw.alusrcb;
  assign pcsrc     = cw.pcsrc;
  assign aluop     = cw.aluop;
  assign illegal   = cw.illegal;
  assign state_dbg = state;

endmodule
